int_claim_arbiter: RTL and testbench

- Interrupt gateway and claim/complete arbiter for the synchronized interrupt vector delivered by the interrupt sync-crossing path.
- Tracks each source as idle, pending or in-service, and picks the highest-priority enabled pending source above a threshold.
- Raises a single interrupt line to the hart and serves claim/complete requests, so each source is serviced exactly once per assertion episode.

---
 rtl/int_claim_arbiter.sv | 112 +++++++++++
 tb/tb_int_claim_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_claim_arbiter.sv
// Interrupt gateway plus claim/complete arbiter: per-source IDLE/PENDING/INSERVICE
// gateways, registered priority pick, and a claim response port toward the hart.
module int_claim_arbiter #(
  parameter int N_SRC  = 4,
  parameter int PRIO_W = 2,
  parameter int ID_W   = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_SRC-1:0]          auto_in_sync,
  input  logic [N_SRC-1:0]          cfg_enable,
  input  logic [N_SRC*PRIO_W-1:0]   cfg_prio,
  input  logic [PRIO_W-1:0]         cfg_threshold,
  output logic                      irq_out,
  input  logic                      claim_req,
  output logic                      claim_resp_valid,
  output logic [ID_W-1:0]           claim_id,
  input  logic                      complete_valid,
  input  logic [ID_W-1:0]           complete_id,
  output logic [2*N_SRC-1:0]        o_dbg_gw_state
);

  // Handshake: claim_req and complete_valid are single-cycle strobes with no
  // ready; every claim_req yields exactly one claim_resp_valid pulse on the next
  // cycle (unless reset is low at that edge); completes never respond.

  typedef enum logic [1:0] {
    GW_IDLE      = 2'd0,
    GW_PENDING   = 2'd1,
    GW_INSERVICE = 2'd2
  } gw_state_e;

  gw_state_e         r_gw_state [N_SRC];
  gw_state_e         w_gw_next  [N_SRC];
  logic [ID_W-1:0]   r_best_id;
  logic [ID_W-1:0]   w_best_id;
  logic [PRIO_W-1:0] w_best_prio;
  logic              r_irq;
  logic              r_resp_valid;
  logic [ID_W-1:0]   r_claim_id;
  logic [N_SRC-1:0]  w_grant;
  logic [N_SRC-1:0]  w_complete_hit;
  logic [N_SRC-1:0]  w_eligible;

  // Grants use the best_id registered before this edge; completes only hit
  // sources already in service, so out-of-range or stale IDs fall through.
  always_comb begin
    w_grant        = '0;
    w_complete_hit = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_grant[i]        = claim_req && (r_best_id == ID_W'(i + 1));
      w_complete_hit[i] = complete_valid && (complete_id == ID_W'(i + 1)) &&
                          (r_gw_state[i] == GW_INSERVICE);
    end
  end

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      w_gw_next[i] = r_gw_state[i];
      case (r_gw_state[i])
        GW_IDLE:      if (auto_in_sync[i] && cfg_enable[i]) w_gw_next[i] = GW_PENDING;
        GW_PENDING:   if (w_grant[i])                       w_gw_next[i] = GW_INSERVICE;
                      else if (!cfg_enable[i])              w_gw_next[i] = GW_IDLE;
        GW_INSERVICE: if (w_complete_hit[i])                w_gw_next[i] = GW_IDLE;
        default:                                            w_gw_next[i] = GW_IDLE;
      endcase
    end
  end

  // A source being granted or dropped this edge is excluded so the registered
  // best_id always names a source that is still PENDING on the next cycle.
  always_comb begin
    w_eligible  = '0;
    w_best_id   = '0;
    w_best_prio = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_eligible[i] = (r_gw_state[i] == GW_PENDING) && !w_grant[i] && cfg_enable[i] &&
                      (cfg_prio[i*PRIO_W +: PRIO_W] > cfg_threshold);
      if (w_eligible[i] && (cfg_prio[i*PRIO_W +: PRIO_W] > w_best_prio)) begin
        w_best_prio = cfg_prio[i*PRIO_W +: PRIO_W];
        w_best_id   = ID_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < N_SRC; i++) r_gw_state[i] <= GW_IDLE;
      r_best_id    <= '0;
      r_irq        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_claim_id   <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) r_gw_state[i] <= w_gw_next[i];
      r_best_id    <= w_best_id;
      r_irq        <= (w_best_id != '0);
      r_resp_valid <= claim_req;
      if (claim_req) r_claim_id <= r_best_id;
    end
  end

  // Debug view: source i occupies bits [2i +: 2], 0=IDLE 1=PENDING 2=INSERVICE.
  always_comb begin
    o_dbg_gw_state = '0;
    for (int i = 0; i < N_SRC; i++) o_dbg_gw_state[2*i +: 2] = r_gw_state[i];
  end

  assign irq_out          = r_irq;
  assign claim_resp_valid = r_resp_valid;
  assign claim_id         = r_claim_id;

endmodule

// File: tb/tb_int_claim_arbiter.sv
// Bench for int_claim_arbiter: directed vector table, hand sequences for the
// multi-cycle corners, and random traffic against a behavioural model.
module tb_int_claim_arbiter;

  logic       clock;
  logic       reset;
  logic [3:0] auto_in_sync;
  logic [3:0] cfg_enable;
  logic [7:0] cfg_prio;
  logic [1:0] cfg_threshold;
  logic       claim_req;
  logic       complete_valid;
  logic [4:0] complete_id;
  logic       irq_out;
  logic       claim_resp_valid;
  logic [4:0] claim_id;
  logic [7:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: one small integer per source, 0 idle, 1 pending, 2 in service.
  int m_st[4];
  int m_best = 0;
  int m_irq  = 0;
  int m_rv   = 0;
  int m_cid  = 0;

  typedef struct {
    logic       rst;
    logic [3:0] insync;
    logic [3:0] en;
    logic [7:0] prio;
    logic [1:0] thr;
    logic       claim;
    logic       cv;
    logic [4:0] cid;
    logic       exp_irq;
    logic       exp_rv;
    logic [4:0] exp_cid;
  } vec_t;

  vec_t tbl[$];

  int_claim_arbiter #(.N_SRC(4), .PRIO_W(2), .ID_W(5)) dut (
    .clock            (clock),
    .reset            (reset),
    .auto_in_sync     (auto_in_sync),
    .cfg_enable       (cfg_enable),
    .cfg_prio         (cfg_prio),
    .cfg_threshold    (cfg_threshold),
    .irq_out          (irq_out),
    .claim_req        (claim_req),
    .claim_resp_valid (claim_resp_valid),
    .claim_id         (claim_id),
    .complete_valid   (complete_valid),
    .complete_id      (complete_id),
    .o_dbg_gw_state   (dbg_state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int prio_of(input int i);
    return (int'(cfg_prio) >> (2 * i)) % 4;
  endfunction

  // Applies the rules to the inputs seen at this edge.
  task automatic model_edge();
    int grant;
    int best;
    int bp;
    if (!reset) begin
      for (int i = 0; i < 4; i++) m_st[i] = 0;
      m_best = 0; m_irq = 0; m_rv = 0; m_cid = 0;
    end else begin
      grant = claim_req ? m_best : 0;
      m_rv  = int'(claim_req);
      if (claim_req) m_cid = m_best;
      best = 0;
      bp   = 0;
      for (int i = 0; i < 4; i++) begin
        if (m_st[i] == 1 && (i + 1) != grant && cfg_enable[i] &&
            prio_of(i) > int'(cfg_threshold) && prio_of(i) > bp) begin
          bp   = prio_of(i);
          best = i + 1;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (m_st[i] == 0) begin
          if (auto_in_sync[i] && cfg_enable[i]) m_st[i] = 1;
        end else if (m_st[i] == 1) begin
          if (grant == i + 1) m_st[i] = 2;
          else if (!cfg_enable[i]) m_st[i] = 0;
        end else if (complete_valid && int'(complete_id) == i + 1) begin
          m_st[i] = 0;
        end
      end
      m_best = best;
      m_irq  = (best != 0) ? 1 : 0;
    end
  endtask

  // One clock: sample at posedge+1, compare against the model, then drop strobes.
  task automatic tick();
    int ms;
    @(posedge clock);
    #1;
    model_edge();
    ms = 0;
    for (int i = 0; i < 4; i++) ms += m_st[i] << (2 * i);
    check("model_irq", int'(irq_out), m_irq);
    check("model_resp_valid", int'(claim_resp_valid), m_rv);
    check("model_claim_id", int'(claim_id), m_cid);
    check("model_gw_state", int'(dbg_state), ms);
    claim_req      = 1'b0;
    complete_valid = 1'b0;
    complete_id    = '0;
  endtask

  task automatic reset_dut();
    reset = 1'b0; auto_in_sync = '0; claim_req = 1'b0; complete_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  function automatic vec_t mk(input logic rst, input logic [3:0] in_v, input logic [7:0] pr,
                              input logic cl, input logic cv, input logic [4:0] cid,
                              input logic ei, input logic erv, input logic [4:0] ecid);
    vec_t v;
    v.rst = rst; v.insync = in_v; v.en = 4'hF; v.prio = pr; v.thr = 2'd0;
    v.claim = cl; v.cv = cv; v.cid = cid;
    v.exp_irq = ei; v.exp_rv = erv; v.exp_cid = ecid;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) m_st[i] = 0;
    reset = 1'b0; auto_in_sync = '0; cfg_enable = 4'hF; cfg_prio = '0;
    cfg_threshold = '0; claim_req = 1'b0; complete_valid = 1'b0; complete_id = '0;
    #1;

    // Reset, single source, priority/tie-break, level re-arm after complete.
    tbl.push_back(mk(0, 4'h0, 8'h03, 0, 0, 5'd0, 0, 0, 5'd0));
    tbl.push_back(mk(0, 4'h0, 8'h03, 0, 0, 5'd0, 0, 0, 5'd0));
    tbl.push_back(mk(1, 4'h0, 8'h03, 0, 0, 5'd0, 0, 0, 5'd0));
    tbl.push_back(mk(1, 4'h1, 8'h03, 0, 0, 5'd0, 0, 0, 5'd0));
    tbl.push_back(mk(1, 4'h1, 8'h03, 0, 0, 5'd0, 1, 0, 5'd0));
    tbl.push_back(mk(1, 4'h1, 8'h03, 1, 0, 5'd0, 0, 1, 5'd1));
    tbl.push_back(mk(1, 4'h1, 8'h03, 0, 0, 5'd0, 0, 0, 5'd1));
    tbl.push_back(mk(1, 4'h0, 8'h03, 0, 1, 5'd1, 0, 0, 5'd1));
    tbl.push_back(mk(1, 4'h0, 8'h03, 0, 0, 5'd0, 0, 0, 5'd1));
    tbl.push_back(mk(1, 4'hE, 8'hF8, 0, 0, 5'd0, 0, 0, 5'd1));
    tbl.push_back(mk(1, 4'hE, 8'hF8, 0, 0, 5'd0, 1, 0, 5'd1));
    tbl.push_back(mk(1, 4'hE, 8'hF8, 1, 0, 5'd0, 1, 1, 5'd3));
    tbl.push_back(mk(1, 4'hE, 8'hF8, 1, 0, 5'd0, 1, 1, 5'd4));
    tbl.push_back(mk(1, 4'hE, 8'hF8, 1, 0, 5'd0, 0, 1, 5'd2));
    tbl.push_back(mk(1, 4'hE, 8'hF8, 1, 0, 5'd0, 0, 1, 5'd0));
    tbl.push_back(mk(1, 4'hE, 8'hF8, 0, 0, 5'd0, 0, 0, 5'd0));
    tbl.push_back(mk(1, 4'hE, 8'hF8, 0, 1, 5'd3, 0, 0, 5'd0));
    tbl.push_back(mk(1, 4'hE, 8'hF8, 0, 0, 5'd0, 0, 0, 5'd0));
    tbl.push_back(mk(1, 4'hE, 8'hF8, 0, 0, 5'd0, 1, 0, 5'd0));

    foreach (tbl[k]) begin
      reset = tbl[k].rst; auto_in_sync = tbl[k].insync; cfg_enable = tbl[k].en;
      cfg_prio = tbl[k].prio; cfg_threshold = tbl[k].thr; claim_req = tbl[k].claim;
      complete_valid = tbl[k].cv; complete_id = tbl[k].cid;
      tick();
      check($sformatf("tbl_irq[%0d]", k), int'(irq_out), int'(tbl[k].exp_irq));
      check($sformatf("tbl_resp_valid[%0d]", k), int'(claim_resp_valid), int'(tbl[k].exp_rv));
      check($sformatf("tbl_claim_id[%0d]", k), int'(claim_id), int'(tbl[k].exp_cid));
    end

    // Threshold gating, then disable while pending.
    reset_dut();
    cfg_enable = 4'hF; cfg_prio = 8'h02; cfg_threshold = 2'd2; auto_in_sync = 4'h1;
    tick(); tick(); tick();
    check("thr_block_irq", int'(irq_out), 0);
    claim_req = 1'b1; tick();
    check("thr_block_resp_valid", int'(claim_resp_valid), 1);
    check("thr_block_claim_id", int'(claim_id), 0);
    cfg_threshold = 2'd1; tick();
    check("thr_lower_irq", int'(irq_out), 1);
    cfg_enable = 4'hE; tick();
    check("disable_gw_idle", int'(dbg_state[1:0]), 0);
    check("disable_irq", int'(irq_out), 0);
    tick();
    claim_req = 1'b1; tick();
    check("disable_claim_id", int'(claim_id), 0);

    // Bad completes leave the in-service source alone; a good one re-arms the level.
    reset_dut();
    cfg_enable = 4'hF; cfg_prio = 8'h0C; cfg_threshold = 2'd0; auto_in_sync = 4'h2;
    tick(); tick();
    check("rearm_irq_up", int'(irq_out), 1);
    claim_req = 1'b1; tick();
    check("rearm_claim_id", int'(claim_id), 2);
    complete_valid = 1'b1; complete_id = 5'd5; tick();
    complete_valid = 1'b1; complete_id = 5'd3; tick();
    check("badcpl_state", int'(dbg_state[3:2]), 2);
    check("badcpl_irq", int'(irq_out), 0);
    complete_valid = 1'b1; complete_id = 5'd2; tick();
    check("cpl_idle", int'(dbg_state[3:2]), 0);
    tick();
    check("rearm_pending", int'(dbg_state[3:2]), 1);
    check("rearm_irq_low", int'(irq_out), 0);
    tick();
    check("rearm_irq", int'(irq_out), 1);

    // Simultaneous claim+complete, and a source rising alongside a claim.
    reset_dut();
    cfg_enable = 4'hF; cfg_prio = 8'h7B; cfg_threshold = 2'd0; auto_in_sync = 4'h8;
    tick(); tick();
    claim_req = 1'b1; tick();
    check("sim_setup_claim_id", int'(claim_id), 4);
    auto_in_sync = 4'h1; tick(); tick();
    check("sim_setup_irq", int'(irq_out), 1);
    claim_req = 1'b1; complete_valid = 1'b1; complete_id = 5'd4; tick();
    check("sim_claim_id", int'(claim_id), 1);
    check("sim_cpl_idle", int'(dbg_state[7:6]), 0);
    auto_in_sync = 4'h3; tick(); tick();
    check("race_setup_irq", int'(irq_out), 1);
    auto_in_sync = 4'h7; claim_req = 1'b1; tick();
    check("race_claim_id", int'(claim_id), 2);
    tick();
    check("race_irq_src3", int'(irq_out), 1);

    // Reset together with a claim while sources are in service.
    reset = 1'b0; claim_req = 1'b1; tick();
    check("rst_mid_resp_valid", int'(claim_resp_valid), 0);
    check("rst_mid_irq", int'(irq_out), 0);
    check("rst_mid_claim_id", int'(claim_id), 0);
    check("rst_mid_gw_state", int'(dbg_state), 0);
    reset = 1'b1;

    // Random traffic against the model.
    reset_dut();
    for (int n = 0; n < 1500; n++) begin
      reset          = ($urandom_range(0, 199) != 0);
      auto_in_sync   = 4'($urandom);
      cfg_enable     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 15) == 0) cfg_prio = 8'($urandom);
      if ($urandom_range(0, 15) == 0) cfg_threshold = 2'($urandom);
      claim_req      = ($urandom_range(0, 2) == 0);
      complete_valid = ($urandom_range(0, 2) == 0);
      complete_id    = 5'($urandom_range(0, 6));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
